// File: rtl/dcache_mem_pkg.sv
// rtl/dcache_mem_pkg.sv - shared state encodings and sizing helpers for the dcache burst memory
//
// Holds the FSM state constants, the beat-count and beat-counter-width
// constant functions, and the byte-lane offset helper used to slice a
// line into beats.
package dcache_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_XFER = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Number of beats needed to move one line.
    function automatic int beats_f(input int line_bytes, input int beat_bytes);
        return line_bytes / beat_bytes;
    endfunction

    // Beat counter width; at least one bit even for single-beat lines.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Bit offset of beat k inside a line.
    function automatic int lane_lsb(input int beat, input int beat_bytes);
        return beat * beat_bytes * 8;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - MEM_LINES x LINE_BYTES storage array with one beat-wide port
//
// Ports:
//   clock    : rising-edge clock (writes only; no reset, contents survive reset)
//   line_idx : line being accessed
//   beat_idx : beat within the line
//   we       : commit wdata to [line_idx][beat_idx] at the clock edge
//   wdata    : beat write data, lowest byte of the beat in bits [7:0]
//   rdata    : combinational beat read data
module dcache_line_store
    import dcache_mem_pkg::*;
#(
    parameter  int MEM_LINES  = 256,
    parameter  int LINE_BYTES = 16,
    parameter  int BEAT_BYTES = 1,
    localparam int BEATS      = beats_f(LINE_BYTES, BEAT_BYTES),
    localparam int IDX_W      = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1,
    localparam int BEAT_W     = beat_cnt_w(BEATS)
) (
    input  logic                    clock,
    input  logic [IDX_W-1:0]        line_idx,
    input  logic [BEAT_W-1:0]       beat_idx,
    input  logic                    we,
    input  logic [BEAT_BYTES*8-1:0] wdata,
    output logic [BEAT_BYTES*8-1:0] rdata
);

    // Stored as beat-wide words so one access is one array element.
    logic [BEAT_BYTES*8-1:0] mem [MEM_LINES][BEATS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[line_idx][beat_idx] <= wdata;
        end
    end

    assign rdata = mem[line_idx][beat_idx];

endmodule

// File: rtl/dcache_burst_memory.sv
// rtl/dcache_burst_memory.sv - line-granular burst backing memory behind the data cache
//
// Ports:
//   clock        : rising-edge clock
//   reset        : synchronous active-high reset (memory contents kept)
//   read, write  : line request, held by the cache until busywait falls
//   address      : line address
//   writedata    : line to write, byte 0 in bits [7:0]
//   readdata     : registered line read, loaded only when a read completes
//   busywait     : combinational, high while an accepted request is in progress
//   access_error : one-cycle pulse in DONE for a conflicting or out-of-range request
module dcache_burst_memory
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 28,
    parameter int MEM_LINES    = 256,
    parameter int LINE_BYTES   = 16,
    parameter int BEAT_BYTES   = 1,
    parameter int INIT_LATENCY = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [LINE_BYTES*8-1:0] writedata,
    output logic [LINE_BYTES*8-1:0] readdata,
    output logic                    busywait,
    output logic                    access_error
);

    localparam int BEATS   = beats_f(LINE_BYTES, BEAT_BYTES);
    localparam int BEAT_W  = beat_cnt_w(BEATS);
    localparam int IDX_W   = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int LINE_W  = LINE_BYTES * 8;
    localparam int BEAT_DW = BEAT_BYTES * 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        LAT_LAST  = 4'(INIT_LATENCY - 1);

    state_t              state_q, state_d;
    logic                op_write_q, op_write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   shadow_q, shadow_d;
    logic [LINE_W-1:0]   readdata_q, readdata_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic                err_q, err_d;
    logic                access_error_q, access_error_d;

    logic                req;
    logic                out_of_range;
    logic                store_we;
    logic [BEAT_DW-1:0]  store_wdata;
    logic [BEAT_DW-1:0]  store_rdata;
    logic [BEAT_DW-1:0]  beat_rdata;
    int                  lsb;

    assign req          = read | write;
    assign out_of_range = 64'(address) >= 64'(MEM_LINES);

    assign busywait = req && (state_q != ST_DONE) && !(state_q == ST_IDLE && read && write);

    assign lsb         = lane_lsb(int'(beat_q), BEAT_BYTES);
    assign store_wdata = wline_q[lsb +: BEAT_DW];
    // Out-of-range transfers keep their timing but never touch the array.
    assign store_we    = (state_q == ST_XFER) && op_write_q && req && !err_q;
    assign beat_rdata  = err_q ? '0 : store_rdata;

    dcache_line_store #(
        .MEM_LINES  (MEM_LINES),
        .LINE_BYTES (LINE_BYTES),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_store (
        .clock    (clock),
        .line_idx (idx_q),
        .beat_idx (beat_q),
        .we       (store_we),
        .wdata    (store_wdata),
        .rdata    (store_rdata)
    );

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wline_d    = wline_q;
        shadow_d   = shadow_q;
        readdata_d = readdata_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (read ^ write) begin
                    op_write_d = write;
                    idx_d      = address[IDX_W-1:0];
                    wline_d    = writedata;
                    beat_d     = '0;
                    lat_d      = '0;
                    err_d      = out_of_range;
                    state_d    = (INIT_LATENCY > 0) ? ST_WAIT : ST_XFER;
                end else if (read && write) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (lat_q == LAT_LAST) begin
                    state_d = ST_XFER;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            ST_XFER: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!op_write_q) begin
                        shadow_d[lsb +: BEAT_DW] = beat_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        // Last beat is merged here so readdata gets the whole line at once.
                        if (!op_write_q) begin
                            readdata_d = shadow_d;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase

        access_error_d = (state_d == ST_DONE) && err_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_write_q     <= 1'b0;
            idx_q          <= '0;
            wline_q        <= '0;
            shadow_q       <= '0;
            readdata_q     <= '0;
            beat_q         <= '0;
            lat_q          <= '0;
            err_q          <= 1'b0;
            access_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_write_q     <= op_write_d;
            idx_q          <= idx_d;
            wline_q        <= wline_d;
            shadow_q       <= shadow_d;
            readdata_q     <= readdata_d;
            beat_q         <= beat_d;
            lat_q          <= lat_d;
            err_q          <= err_d;
            access_error_q <= access_error_d;
        end
    end

    assign readdata     = readdata_q;
    assign access_error = access_error_q;

endmodule

// File: tb/tb_dcache_burst_memory.sv
// tb/tb_dcache_burst_memory.sv - self-checking bench for dcache_burst_memory
module tb_dcache_burst_memory;

    logic         clock = 1'b0;
    logic         reset;
    logic         r0, w0, r1, w1;
    logic [27:0]  a0, a1;
    logic [127:0] wd0, wd1, rd0, rd1;
    logic         bw0, bw1, ae0, ae1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] model0[int];
    logic [127:0] model1[int];
    logic [127:0] last_rd[2];

    always #5 clock = ~clock;

    dcache_burst_memory dut0 (
        .clock(clock), .reset(reset), .read(r0), .write(w0), .address(a0),
        .writedata(wd0), .readdata(rd0), .busywait(bw0), .access_error(ae0)
    );

    dcache_burst_memory #(.BEAT_BYTES(4), .INIT_LATENCY(3)) dut1 (
        .clock(clock), .reset(reset), .read(r1), .write(w1), .address(a1),
        .writedata(wd1), .readdata(rd1), .busywait(bw1), .access_error(ae1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic rd, input logic wr,
                           input logic [27:0] addr, input logic [127:0] data);
        if (sel == 0) begin
            r0 = rd; w0 = wr; a0 = addr; wd0 = data;
        end else begin
            r1 = rd; w1 = wr; a1 = addr; wd1 = data;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bw0 : bw1;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? ae0 : ae1;
    endfunction

    function automatic logic [127:0] get_rd(input int sel);
        return (sel == 0) ? rd0 : rd1;
    endfunction

    function automatic logic [127:0] model_get(input int sel, input int addr);
        if (addr >= 256) return '0;
        if (sel == 0) return model0.exists(addr) ? model0[addr] : '0;
        return model1.exists(addr) ? model1[addr] : '0;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] b);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    // Drives one full request, counts busy cycles and checks the DONE cycle.
    task automatic txn(input int sel, input logic rd, input logic wr, input int addr,
                       input logic [127:0] data, input int exp_busy, input logic exp_err,
                       input string tag);
        int n;
        logic [127:0] exp_line;
        n = 0;
        if (rd) exp_q.push_back(model_get(sel, addr));
        set_req(sel, rd, wr, 28'(addr), data);
        #1;
        while (get_busy(sel) && n < 200) begin
            n++;
            @(negedge clock); #1;
        end
        check({tag, " busy cycles"}, 128'(n), 128'(exp_busy));
        check({tag, " access_error"}, 128'(get_err(sel)), 128'(exp_err));
        if (rd) begin
            exp_line = exp_q.pop_front();
            check({tag, " readdata"}, get_rd(sel), exp_line);
            last_rd[sel] = exp_line;
        end
        if (wr && addr < 256) begin
            if (sel == 0) model0[addr] = data; else model1[addr] = data;
        end
        set_req(sel, 1'b0, 1'b0, 28'(addr), data);
        @(negedge clock); #1;
        check({tag, " error cleared"}, 128'(get_err(sel)), 128'(0));
    endtask

    initial begin
        logic [127:0] pat5;
        logic [127:0] mixed;

        for (int i = 0; i < 16; i++) pat5[i*8 +: 8] = 8'(i);

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        #1;
        check("reset readdata0", rd0, '0);
        check("reset readdata1", rd1, '0);
        check("reset access_error", 128'(ae0), 128'(0));
        check("reset busywait", 128'(bw0), 128'(0));
        reset = 1'b0;
        @(negedge clock); #1;

        // Default geometry: full line write then read back.
        txn(0, 1'b0, 1'b1, 5, pat5, 17, 1'b0, "wr line5");
        txn(0, 1'b1, 1'b0, 5, '0, 17, 1'b0, "rd line5");

        // Four-byte beats with three idle cycles ahead of the burst.
        txn(1, 1'b0, 1'b1, 2, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 8, 1'b0, "wr4 line2");
        txn(1, 1'b1, 1'b0, 2, '0, 8, 1'b0, "rd4 line2");

        // Read and write together: refused at once, error pulse, no store.
        set_req(0, 1'b1, 1'b1, 28'd5, fill(8'hFF));
        #1;
        check("conflict busywait idle", 128'(bw0), 128'(0));
        @(negedge clock); #1;
        check("conflict access_error", 128'(ae0), 128'(1));
        check("conflict busywait done", 128'(bw0), 128'(0));
        set_req(0, 1'b0, 1'b0, 28'd5, '0);
        @(negedge clock); #1;
        check("conflict error pulse end", 128'(ae0), 128'(0));
        txn(0, 1'b1, 1'b0, 5, '0, 17, 1'b0, "rd line5 after conflict");

        // Out-of-range accesses keep timing, flag an error, never alias.
        txn(0, 1'b0, 1'b1, 44, fill(8'h3C), 17, 1'b0, "wr line44");
        txn(0, 1'b0, 1'b1, 300, fill(8'h77), 17, 1'b1, "wr oor300");
        txn(0, 1'b1, 1'b0, 300, '0, 17, 1'b1, "rd oor300");
        txn(0, 1'b1, 1'b0, 44, '0, 17, 1'b0, "rd line44");

        // Write dropped during beat 5: beats 0-4 stay committed.
        txn(0, 1'b0, 1'b1, 7, fill(8'h55), 17, 1'b0, "wr line7");
        set_req(0, 1'b0, 1'b1, 28'd7, fill(8'hAA));
        repeat (6) begin
            @(negedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 28'd7, '0);
        #1;
        check("abort busywait", 128'(bw0), 128'(0));
        @(negedge clock); #1;
        check("abort access_error", 128'(ae0), 128'(0));
        check("abort readdata kept", rd0, last_rd[0]);
        mixed = fill(8'h55);
        for (int i = 0; i < 5; i++) mixed[i*8 +: 8] = 8'hAA;
        model0[7] = mixed;
        txn(0, 1'b1, 1'b0, 7, '0, 17, 1'b0, "rd line7 partial");

        // Reset during beat 9 of a read that stays requested.
        set_req(0, 1'b1, 1'b0, 28'd5, '0);
        repeat (10) begin
            @(negedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        check("midburst reset readdata", rd0, '0);
        check("midburst reset busywait", 128'(bw0), 128'(1));
        check("midburst reset access_error", 128'(ae0), 128'(0));
        txn(0, 1'b1, 1'b0, 5, '0, 17, 1'b0, "rd line5 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
